// File: rtl/router_dest_fifo_if.sv
// Handshake bundle between the router core, the destination buffer and the destination agent.
// master drives writes and read requests; slave is the buffer itself.
interface router_dest_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              wr_en;
    logic              sop_in;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              valid_out;
    logic              read_en;
    logic [DATA_W-1:0] data_out;
    logic              pkt_done;
    logic              soft_rst;

    modport master (
        output wr_en, sop_in, data_in, read_en,
        input  full, empty, count, valid_out, data_out, pkt_done, soft_rst
    );

    modport slave (
        input  wr_en, sop_in, data_in, read_en,
        output full, empty, count, valid_out, data_out, pkt_done, soft_rst
    );
endinterface

// File: rtl/router_dest_fifo.sv
// Destination-port byte FIFO with packet-end tracking from the header length field
// and a stall-timeout flush that empties the buffer when the reader stops draining it.
module router_dest_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                clk,
    input  logic                rst,
    router_dest_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = DATA_W - 1;

    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [CW-1:0]     count_q;
    logic [TW-1:0]     timer;
    logic [RW-1:0]     remaining;
    logic [DATA_W-1:0] data_q;
    logic              pkt_done_q, soft_rst_q;

    logic              empty_w, full_w, stall, flush, wr_fire, rd_fire;
    logic [DATA_W:0]   rd_entry;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CW'(DEPTH));
    assign stall    = !empty_w && !bus.read_en;
    assign flush    = stall && (timer == TW'(TIMEOUT - 1));
    // A write landing on the flush edge is dropped so the buffer really comes out empty.
    assign wr_fire  = bus.wr_en && !full_w && !flush;
    assign rd_fire  = bus.read_en && !empty_w;
    assign rd_entry = mem[rptr];

    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.count     = count_q;
    assign bus.valid_out = !empty_w;
    assign bus.data_out  = data_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.soft_rst  = soft_rst_q;

    // NOTE: storage has no reset; stale entries are unreachable once the pointers and count clear.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wptr] <= {bus.sop_in, bus.data_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            timer      <= '0;
            remaining  <= '0;
            data_q     <= '0;
            pkt_done_q <= 1'b0;
            soft_rst_q <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            soft_rst_q <= 1'b0;
            if (flush) begin
                wptr       <= '0;
                rptr       <= '0;
                count_q    <= '0;
                timer      <= '0;
                remaining  <= '0;
                data_q     <= '0;
                soft_rst_q <= 1'b1;
            end else begin
                timer <= stall ? timer + 1'b1 : '0;
                if (wr_fire) wptr <= wptr + 1'b1;
                if (rd_fire) begin
                    rptr   <= rptr + 1'b1;
                    data_q <= rd_entry[DATA_W-1:0];
                    // Header reload covers payload plus the trailing parity byte.
                    if (rd_entry[DATA_W]) begin
                        remaining <= RW'(rd_entry[DATA_W-1:2]) + 1'b1;
                    end else if (remaining != '0) begin
                        remaining  <= remaining - 1'b1;
                        pkt_done_q <= (remaining == RW'(1));
                    end
                end
                case ({wr_fire, rd_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule
